aes_key_sched_iter: RTL

Iterative, multi-length AES key scheduler: expands a 128-, 192- or 256-bit cipher key into the 11, 13 or 15 round keys defined by FIPS-197, generating one 32-bit schedule word per clock through a single 4-S-box SubWord datapath. It replaces the fully unrolled AES-128 key-expansion network in the cipher core. Round keys are held in an internal word store and served to the round pipeline through a registered read port.

---
 rtl/aes_key_sched_iter.sv | 270 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/aes_key_sched_iter.sv
// aes_key_sched_iter: iterative FIPS-197 key expansion for AES-128/192/256, one schedule word per clock.
// Build option AES_KS_ZEROIZE_EN clears the whole word store on rst and on every accepted start.
module aes_key_sched_iter #(
    parameter int MAX_KEY_BITS = 256
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   key_len,
    input  logic [255:0] key,
    output logic         ready,
    output logic         done,
    output logic         key_valid,
    output logic         err,
    input  logic         rd_en,
    input  logic [3:0]   rd_round,
    output logic [127:0] rd_key,
    output logic         rd_valid,
    output logic         rd_err
);

    localparam int T_MAX = (MAX_KEY_BITS >= 256) ? 60 : ((MAX_KEY_BITS >= 192) ? 52 : 44);
    localparam logic [1:0] MAX_MODE = (MAX_KEY_BITS >= 256) ? 2'd2 : ((MAX_KEY_BITS >= 192) ? 2'd1 : 2'd0);

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic {
        IDLE = 1'b0,
        GEN  = 1'b1
    } state_t;

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [3:0] nk_of(input logic [1:0] mode);
        case (mode)
            2'b00:   return 4'd4;
            2'b01:   return 4'd6;
            2'b10:   return 4'd8;
            default: return 4'd4;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(input logic [1:0] mode);
        case (mode)
            2'b00:   return 4'd10;
            2'b01:   return 4'd12;
            2'b10:   return 4'd14;
            default: return 4'd10;
        endcase
    endfunction

    function automatic logic [5:0] last_idx_of(input logic [1:0] mode);
        case (mode)
            2'b00:   return 6'd43;
            2'b01:   return 6'd51;
            2'b10:   return 6'd59;
            default: return 6'd43;
        endcase
    endfunction

    state_t         state_r;
    state_t         state_nxt_s;
    logic [1:0]     mode_r;
    logic [5:0]     idx_r;
    logic [2:0]     phase_r;
    logic [7:0]     rcon_r;
    logic           ready_r;
    logic           done_r;
    logic           key_valid_r;
    logic           err_r;
    logic [127:0]   rd_key_r;
    logic           rd_valid_r;
    logic           rd_err_r;
    logic [31:0]    store_r [T_MAX];

    logic           len_ok_s;
    logic           accept_s;
    logic           reject_s;
    logic           gen_wr_s;
    logic           last_s;
    logic [3:0]     start_nk_s;
    logic [3:0]     nk_s;
    logic [31:0]    prev_s;
    logic [31:0]    back_s;
    logic [31:0]    sub_in_s;
    logic [31:0]    sub_out_s;
    logic [31:0]    temp_s;
    logic [31:0]    new_word_s;
    logic [5:0]     rd_base_s;
    logic [127:0]   rd_data_s;
    logic           rd_ok_s;

    assign len_ok_s   = (key_len != 2'b11) && (key_len <= MAX_MODE);
    assign start_nk_s = nk_of(key_len);
    assign nk_s       = nk_of(mode_r);
    assign prev_s     = store_r[idx_r - 6'd1];
    assign back_s     = store_r[idx_r - {2'b00, nk_s}];

    // Next-state and strobe decode for the IDLE/GEN controller
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        reject_s    = 1'b0;
        gen_wr_s    = 1'b0;
        last_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (start && len_ok_s) begin
                    accept_s    = 1'b1;
                    state_nxt_s = GEN;
                end else if (start) begin
                    reject_s    = 1'b1;
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            GEN: begin
                gen_wr_s = 1'b1;
                if (idx_r == last_idx_of(mode_r)) begin
                    last_s      = 1'b1;
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = GEN;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Schedule word datapath: one shared SubWord layer, RotWord only on phase 0
    always_comb begin
        sub_in_s  = (phase_r == 3'd0) ? {prev_s[23:0], prev_s[31:24]} : prev_s;
        sub_out_s = sub_word(sub_in_s);
        if (phase_r == 3'd0) begin
            temp_s = sub_out_s ^ {rcon_r, 24'h000000};
        end else if ((nk_s == 4'd8) && (phase_r == 3'd4)) begin
            temp_s = sub_out_s;
        end else begin
            temp_s = prev_s;
        end
        new_word_s = back_s ^ temp_s;
    end

    // Read decode: only a complete schedule in IDLE, rounds 0..Nr of the stored mode
    always_comb begin
        rd_base_s = {rd_round, 2'b00};
        rd_data_s = {store_r[rd_base_s], store_r[rd_base_s + 6'd1],
                     store_r[rd_base_s + 6'd2], store_r[rd_base_s + 6'd3]};
        if (rd_en && key_valid_r && (state_r == IDLE) && (rd_round <= nr_of(mode_r))) begin
            rd_ok_s = 1'b1;
        end else begin
            rd_ok_s = 1'b0;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Control registers: word index, phase, rcon and status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_r      <= 2'b00;
            idx_r       <= 6'd0;
            phase_r     <= 3'd0;
            rcon_r      <= 8'h00;
            ready_r     <= 1'b1;
            done_r      <= 1'b0;
            key_valid_r <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            ready_r <= (state_nxt_s == IDLE);
            done_r  <= last_s;
            err_r   <= reject_s;
            if (accept_s) begin
                key_valid_r <= 1'b0;
                mode_r      <= key_len;
                idx_r       <= {2'b00, start_nk_s};
                phase_r     <= 3'd0;
                rcon_r      <= 8'h01;
            end else if (gen_wr_s) begin
                key_valid_r <= last_s;
                idx_r       <= idx_r + 6'd1;
                phase_r     <= (({1'b0, phase_r} + 4'd1) == nk_s) ? 3'd0 : (phase_r + 3'd1);
                if (phase_r == 3'd0) begin
                    rcon_r <= xtime(rcon_r);
                end
            end
        end
    end

    // Word store; the RAM itself has no reset unless zeroization is built in
    always_ff @(posedge clk) begin
`ifdef AES_KS_ZEROIZE_EN
        if (rst || accept_s) begin
            for (int k = 0; k < T_MAX; k++) begin
                store_r[k] <= 32'h0;
            end
        end
`endif
        if (!rst && accept_s) begin
            for (int k = 0; k < 8; k++) begin
                if (k < int'(start_nk_s)) begin
                    store_r[k] <= key[255 - 32*k -: 32];
                end
            end
        end else if (!rst && gen_wr_s) begin
            store_r[idx_r] <= new_word_s;
        end
    end

    // Registered round-key read port
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_key_r   <= 128'h0;
            rd_valid_r <= 1'b0;
            rd_err_r   <= 1'b0;
        end else begin
            rd_valid_r <= rd_ok_s;
            rd_err_r   <= rd_en && !rd_ok_s;
`ifdef AES_KS_ZEROIZE_EN
            rd_key_r   <= rd_ok_s ? rd_data_s : 128'h0;
`else
            if (rd_en) begin
                rd_key_r <= rd_ok_s ? rd_data_s : 128'h0;
            end
`endif
        end
    end

    assign ready     = ready_r;
    assign done      = done_r;
    assign key_valid = key_valid_r;
    assign err       = err_r;
    assign rd_key    = rd_key_r;
    assign rd_valid  = rd_valid_r;
    assign rd_err    = rd_err_r;

endmodule
